grf_wb_queue: RTL and testbench

Write-back queue that sits between the execute/memory stages and the general register file (GRF) write port. It accepts register write requests (pc, register address, data) through a valid/ready handshake, buffers them in order, and drains at most one per cycle onto the GRF write port (wEn/wA/wD/pc). A two-port lookup reports whether a register has a pending, not-yet-committed write and returns the youngest pending value for forwarding.

---
 rtl/grf_wb_queue.sv | 107 ++++++++++
 tb/tb_grf_wb_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// In-order write-back queue in front of the GRF write port, with a two-port
// lookup that forwards the youngest pending value for a register.
module grf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [4:0]                 in_addr,
   input  logic [31:0]                in_data,
   input  logic                       drain_en,
   output logic                       wEn,
   output logic [4:0]                 wA,
   output logic [31:0]                wD,
   output logic [31:0]                pc,
   input  logic [4:0]                 q_addr1,
   input  logic [4:0]                 q_addr2,
   output logic                       q_hit1,
   output logic                       q_hit2,
   output logic [31:0]                q_data1,
   output logic [31:0]                q_data2,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_pc_mem   [DEPTH];
   logic [4:0]    r_addr_mem [DEPTH];
   logic [31:0]   r_data_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // Writes to r0 complete the handshake but never occupy a slot.
   assign w_push  = in_valid && !w_full && (in_addr != 5'd0);
   assign w_pop   = drain_en && !w_empty;

   assign in_ready = !w_full;
   assign full     = w_full;
   assign empty    = w_empty;
   assign count    = r_count;

   assign wEn = w_pop;
   assign wA  = w_pop ? r_addr_mem[r_rd_ptr] : 5'd0;
   assign wD  = w_pop ? r_data_mem[r_rd_ptr] : 32'd0;
   assign pc  = w_pop ? r_pc_mem[r_rd_ptr]   : 32'd0;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= in_pc;
         r_addr_mem[r_wr_ptr] <= in_addr;
         r_data_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Walk from oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      logic [AW-1:0] v_idx;
      v_idx   = '0;
      q_hit1  = 1'b0;
      q_hit2  = 1'b0;
      q_data1 = 32'd0;
      q_data2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         v_idx = r_rd_ptr + AW'(i);
         if (CW'(i) < r_count) begin
            if (q_addr1 != 5'd0 && r_addr_mem[v_idx] == q_addr1) begin
               q_hit1  = 1'b1;
               q_data1 = r_data_mem[v_idx];
            end
            if (q_addr2 != 5'd0 && r_addr_mem[v_idx] == q_addr2) begin
               q_hit2  = 1'b1;
               q_data2 = r_data_mem[v_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: reset, single write, fill/hold/drain with
// wrap, r0 discard, forwarding, simultaneous push/pop, mid-operation reset.
module tb_grf_wb_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        drain_en;
   logic        wEn;
   logic [4:0]  wA;
   logic [31:0] wD;
   logic [31:0] pc;
   logic [4:0]  q_addr1;
   logic [4:0]  q_addr2;
   logic        q_hit1;
   logic        q_hit2;
   logic [31:0] q_data1;
   logic [31:0] q_data2;
   logic        empty;
   logic        full;
   logic [2:0]  count;

   int n_vec = 0;
   int n_err = 0;

   grf_wb_queue #(.DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pc    (in_pc),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .drain_en (drain_en),
      .wEn      (wEn),
      .wA       (wA),
      .wD       (wD),
      .pc       (pc),
      .q_addr1  (q_addr1),
      .q_addr2  (q_addr2),
      .q_hit1   (q_hit1),
      .q_hit2   (q_hit2),
      .q_data1  (q_data1),
      .q_data2  (q_data2),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] p, input logic [4:0] a,
                        input logic [31:0] d);
      in_valid = v;
      in_pc    = p;
      in_addr  = a;
      in_data  = d;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_wEn"}, {31'd0, wEn}, 32'd0);
      chk({tag, "_wA"},  {27'd0, wA},  32'd0);
      chk({tag, "_wD"},  wD,           32'd0);
      chk({tag, "_pc"},  pc,           32'd0);
   endtask

   logic [4:0]  exp_a [5];
   logic [31:0] exp_d [5];
   logic [31:0] exp_p [5];

   initial begin
      exp_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10};
      exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hAA};
      exp_p = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h200};

      reset    = 1'b1;
      drain_en = 1'b1;
      q_addr1  = 5'd5;
      q_addr2  = 5'd7;
      drive(1'b0, 32'd0, 5'd0, 32'd0);

      // reset asserted mid-cycle, before any clock edge
      #2 reset = 1'b0;
      #1;
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full",  {31'd0, full},  32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk_idle("rst");
      chk("rst_hit1",  {31'd0, q_hit1}, 32'd0);
      chk("rst_hit2",  {31'd0, q_hit2}, 32'd0);
      chk("rst_data1", q_data1, 32'd0);
      chk("rst_data2", q_data2, 32'd0);
      tick;
      tick;
      reset = 1'b1;
      tick;

      // single write
      drive(1'b1, 32'h3000, 5'd5, 32'h1234);
      #1;
      chk("sw_pre_wEn", {31'd0, wEn}, 32'd0);
      tick;
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      #1;
      chk("sw_wEn", {31'd0, wEn}, 32'd1);
      chk("sw_wA",  {27'd0, wA},  32'd5);
      chk("sw_wD",  wD,           32'h1234);
      chk("sw_pc",  pc,           32'h3000);
      chk("sw_hit_head",  {31'd0, q_hit1}, 32'd1);
      chk("sw_data_head", q_data1, 32'h1234);
      tick;
      chk("sw_after_wEn",   {31'd0, wEn},   32'd0);
      chk("sw_after_empty", {31'd0, empty}, 32'd1);

      // fill and hold
      drain_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, exp_p[k], exp_a[k], exp_d[k]);
         #1;
         chk("fill_ready", {31'd0, in_ready}, 32'd1);
         tick;
      end
      drive(1'b1, 32'h999, 5'd9, 32'h99);
      #1;
      chk("full_flag",  {31'd0, full},     32'd1);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      chk("full_count", {29'd0, count},    32'd4);
      chk("hold_wEn",   {31'd0, wEn},      32'd0);
      tick;
      chk("full_rej_count", {29'd0, count}, 32'd4);
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      drain_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) drive(1'b1, exp_p[4], exp_a[4], exp_d[4]);
         else        drive(1'b0, 32'd0, 5'd0, 32'd0);
         #1;
         if (k == 2) chk("drain_count", {29'd0, count}, 32'd3);
         chk($sformatf("drain%0d_wEn", k), {31'd0, wEn}, 32'd1);
         chk($sformatf("drain%0d_wA", k),  {27'd0, wA},  {27'd0, exp_a[k]});
         chk($sformatf("drain%0d_wD", k),  wD,           exp_d[k]);
         chk($sformatf("drain%0d_pc", k),  pc,           exp_p[k]);
         tick;
      end
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      #1;
      chk("drain_empty", {31'd0, empty}, 32'd1);
      chk_idle("drain_done");

      // address 0 discard
      drive(1'b1, 32'h400, 5'd0, 32'hFFFF);
      q_addr1 = 5'd0;
      #1;
      chk("a0_ready", {31'd0, in_ready}, 32'd1);
      tick;
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      #1;
      chk("a0_count", {29'd0, count},  32'd0);
      chk("a0_hit",   {31'd0, q_hit1}, 32'd0);
      chk_idle("a0");
      tick;
      chk("a0_wEn_late", {31'd0, wEn}, 32'd0);

      // forwarding
      drain_en = 1'b0;
      drive(1'b1, 32'h500, 5'd7, 32'hA);
      tick;
      drive(1'b1, 32'h504, 5'd7, 32'hB);
      tick;
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      q_addr1 = 5'd7;
      q_addr2 = 5'd8;
      #1;
      chk("fwd_count", {29'd0, count},  32'd2);
      chk("fwd_hit1",  {31'd0, q_hit1}, 32'd1);
      chk("fwd_data1", q_data1,         32'hB);
      chk("fwd_hit2",  {31'd0, q_hit2}, 32'd0);
      chk("fwd_data2", q_data2,         32'd0);

      // simultaneous push and pop with two entries queued
      drain_en = 1'b1;
      drive(1'b1, 32'h508, 5'd8, 32'hC);
      #1;
      chk("pp0_wA", {27'd0, wA}, 32'd7);
      chk("pp0_wD", wD,          32'hA);
      tick;
      drive(1'b1, 32'h50C, 5'd9, 32'hD);
      #1;
      chk("pp1_count", {29'd0, count}, 32'd2);
      chk("pp1_wA",    {27'd0, wA},    32'd7);
      chk("pp1_wD",    wD,             32'hB);
      chk("pp1_pc",    pc,             32'h504);
      chk("pp1_hit2",  {31'd0, q_hit2}, 32'd1);
      chk("pp1_data2", q_data2,         32'hC);
      chk("pp1_data1", q_data1,         32'hB);
      tick;
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      #1;
      chk("pp2_count", {29'd0, count}, 32'd2);
      chk("pp2_wA",    {27'd0, wA},    32'd8);
      chk("pp2_wD",    wD,             32'hC);
      chk("pp2_hit1",  {31'd0, q_hit1}, 32'd0);
      tick;
      chk("pp3_wA", {27'd0, wA}, 32'd9);
      chk("pp3_wD", wD,          32'hD);
      tick;
      chk("pp_empty", {31'd0, empty}, 32'd1);
      chk("pp_wEn",   {31'd0, wEn},   32'd0);

      // reset mid-operation drops pending entries
      drain_en = 1'b0;
      drive(1'b1, 32'h600, 5'd3, 32'h33);
      tick;
      drive(1'b1, 32'h604, 5'd4, 32'h44);
      tick;
      drive(1'b0, 32'd0, 5'd0, 32'd0);
      q_addr1 = 5'd3;
      #1;
      chk("mr_pre_count", {29'd0, count}, 32'd2);
      chk("mr_pre_hit",   {31'd0, q_hit1}, 32'd1);
      drain_en = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("mr_count", {29'd0, count},  32'd0);
      chk("mr_empty", {31'd0, empty},  32'd1);
      chk("mr_hit",   {31'd0, q_hit1}, 32'd0);
      chk_idle("mr");
      tick;
      reset = 1'b1;
      tick;
      chk("mr_after_wEn",   {31'd0, wEn},   32'd0);
      chk("mr_after_count", {29'd0, count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
